// File: rtl/ps2_host.sv
// ps2_host -- host-side PS/2 port controller.
//
// Receives device-to-host frames (start, 8 data bits LSB first, odd parity,
// stop). Sends host-to-device command bytes using clock inhibit,
// request-to-send and ACK detection. Everything runs in the clk_sys domain.
//
// Optional feature: define PS2_HOST_TIMEOUT_EN to add the frame watchdog.
// Without it, a stalled frame waits until reset or, for RX, until tx_start.
//
// Ports:
//   clk_sys, rst_n            system clock, async active-low reset
//   ps2_clk_in, ps2_dat_in    resolved PS/2 line levels (asynchronous)
//   ps2_clk_out, ps2_dat_out  open-drain style drives: 0 pulls low, 1 releases
//   rx_inhibit                hold the clock low while idle
//   tx_data, tx_start         command byte and one-cycle send request
//   tx_busy, tx_done, tx_err  transmit status; done/err are 1-cycle pulses
//   rx_data, rx_valid, rx_err last received byte and 1-cycle status pulses
module ps2_host #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  input  logic       rx_inhibit,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, RX_DATA, RX_PAR, RX_STOP,
    TX_INH, TX_RTS, TX_DATA, TX_PAR, TX_STOP, TX_ACK
  } state_t;

  state_t          state, state_nxt;
  logic            clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic            fe;
  logic [IW-1:0]   icnt, icnt_nxt;
  logic [3:0]      bcnt, bcnt_nxt;
  logic [7:0]      sh, sh_nxt;
  logic            par, par_nxt;
  logic [7:0]      rx_data_nxt;
  logic            rx_valid_nxt, rx_err_nxt, tx_done_nxt, tx_err_nxt, busy_nxt;
  logic            clk_nxt, dat_nxt;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fe = clk_prev & ~clk_s2;

`ifdef PS2_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd, wd_nxt;
  logic          wd_fire;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) wd <= '0;
    else        wd <= wd_nxt;
  end
`endif

  always_comb begin
    state_nxt    = state;
    icnt_nxt     = icnt;
    bcnt_nxt     = bcnt;
    sh_nxt       = sh;
    par_nxt      = par;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    rx_err_nxt   = 1'b0;
    tx_done_nxt  = 1'b0;
    tx_err_nxt   = 1'b0;
    busy_nxt     = tx_busy;
    clk_nxt      = 1'b1;
    dat_nxt      = ps2_dat_out;

    case (state)
      IDLE: begin
        clk_nxt = ~rx_inhibit;
        dat_nxt = 1'b1;
        if (fe && !dat_s2 && !rx_inhibit) begin
          state_nxt = RX_DATA;
          bcnt_nxt  = '0;
        end
      end
      RX_DATA: if (fe) begin
        sh_nxt   = {dat_s2, sh[7:1]};
        bcnt_nxt = bcnt + 4'd1;
        if (bcnt == 4'd7) state_nxt = RX_PAR;
      end
      RX_PAR: if (fe) begin
        par_nxt   = dat_s2;
        state_nxt = RX_STOP;
      end
      RX_STOP: if (fe) begin
        if (dat_s2 && (^sh ^ par)) begin
          rx_data_nxt  = sh;
          rx_valid_nxt = 1'b1;
        end else begin
          rx_err_nxt   = 1'b1;
        end
        state_nxt = IDLE;
      end
      TX_INH: begin
        clk_nxt = 1'b0;
        dat_nxt = 1'b1;
        if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
          // Release clock and pull data low: request-to-send / start bit.
          state_nxt = TX_RTS;
          clk_nxt   = 1'b1;
          dat_nxt   = 1'b0;
        end else begin
          icnt_nxt  = icnt + 1'b1;
        end
      end
      // Bits change just after the device's falling edge so they are
      // settled well before the device samples on its rising edge.
      TX_RTS, TX_DATA: if (fe) begin
        dat_nxt   = sh[0];
        sh_nxt    = {1'b0, sh[7:1]};
        bcnt_nxt  = bcnt + 4'd1;
        state_nxt = (bcnt == 4'd7) ? TX_PAR : TX_DATA;
      end
      TX_PAR: if (fe) begin
        dat_nxt   = par;
        state_nxt = TX_STOP;
      end
      TX_STOP: if (fe) begin
        dat_nxt   = 1'b1;
        state_nxt = TX_ACK;
      end
      TX_ACK: if (fe) begin
        if (!dat_s2) tx_done_nxt = 1'b1;
        else         tx_err_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        dat_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef PS2_HOST_TIMEOUT_EN
    // Watchdog restarts on every device edge and when RTS is raised.
    wd_fire = (state != IDLE) && (state != TX_INH) && !fe &&
              (wd == WW'(TIMEOUT_CYCLES - 1));
    if (fe || (state_nxt == TX_RTS && state != TX_RTS)) wd_nxt = '0;
    else if (wd != WW'(TIMEOUT_CYCLES))                 wd_nxt = wd + 1'b1;
    else                                                wd_nxt = wd;
    if (wd_fire) begin
      if (state inside {RX_DATA, RX_PAR, RX_STOP}) rx_err_nxt = 1'b1;
      else                                         tx_err_nxt = 1'b1;
      busy_nxt  = 1'b0;
      clk_nxt   = 1'b1;
      dat_nxt   = 1'b1;
      state_nxt = IDLE;
    end
`endif

    // New command wins over any receive in progress, which is dropped silently.
    if (tx_start && !tx_busy) begin
      state_nxt    = TX_INH;
      busy_nxt     = 1'b1;
      sh_nxt       = tx_data;
      par_nxt      = ~^tx_data;
      bcnt_nxt     = '0;
      icnt_nxt     = '0;
      clk_nxt      = 1'b0;
      dat_nxt      = 1'b1;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      rx_err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      icnt        <= '0;
      bcnt        <= '0;
      sh          <= '0;
      par         <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      tx_busy     <= 1'b0;
      ps2_clk_out <= 1'b1;
      ps2_dat_out <= 1'b1;
    end else begin
      state       <= state_nxt;
      icnt        <= icnt_nxt;
      bcnt        <= bcnt_nxt;
      sh          <= sh_nxt;
      par         <= par_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      rx_err      <= rx_err_nxt;
      tx_done     <= tx_done_nxt;
      tx_err      <= tx_err_nxt;
      tx_busy     <= busy_nxt;
      ps2_clk_out <= clk_nxt;
      ps2_dat_out <= dat_nxt;
    end
  end
endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host -- directed bench for ps2_host with a wired-AND device model.
module tb_ps2_host;
  localparam int H = 20;  // device clock half period in clk_sys cycles

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       rx_inhibit = 1'b0, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_out, ps2_dat_out, tx_busy, tx_done, tx_err, rx_valid, rx_err;
  logic [7:0] rx_data;
  logic       clk_line, dat_line;

  int checks = 0, failures = 0;
  int n_rxv = 0, n_rxe = 0, n_txd = 0, n_txe = 0;

  assign clk_line = ps2_clk_out & dev_clk;
  assign dat_line = ps2_dat_out & dev_dat;

  always #5 clk_sys = ~clk_sys;

  ps2_host #(.INHIBIT_CYCLES(3000), .TIMEOUT_CYCLES(100)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
    .rx_inhibit(rx_inhibit), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  // Pulse counters: counting high cycles also catches over-long pulses.
  always @(negedge clk_sys) begin
    if (rx_valid) n_rxv <= n_rxv + 1;
    if (rx_err)   n_rxe <= n_rxe + 1;
    if (tx_done)  n_txd <= n_txd + 1;
    if (tx_err)   n_txe <= n_txe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Device-to-host: bits[0] first (start), one bit per device clock pulse.
  task automatic dev_frame(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      dev_dat = bits[i];
      repeat (H) @(posedge clk_sys);
      dev_clk = 1'b0;
      repeat (H) @(posedge clk_sys);
      dev_clk = 1'b1;
    end
    repeat (H) @(posedge clk_sys);
    dev_dat = 1'b1;
  endtask

  task automatic tx_go(input logic [7:0] b);
    @(negedge clk_sys);
    tx_data  = b;
    tx_start = 1'b1;
    @(posedge clk_sys);
    #1;
    tx_start = 1'b0;
    chk("busy_rise", tx_busy, 1);
    chk("clk_fall", ps2_clk_out, 0);
  endtask

  // Counts cycles the host holds its clock low, returns on release (bounded).
  task automatic dev_wait_release(output int lowcnt);
    lowcnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_sys);
      if (ps2_clk_out == 1'b0) lowcnt++;
      else if (lowcnt > 0) break;
    end
  endtask

  // Host-to-device: device clocks 10 bits, samples before each rising edge,
  // then answers with an ACK (data low) on an 11th pulse if ack=1.
  task automatic dev_host_rx(output logic [7:0] b, output logic p, output logic s,
                             output logic st, input logic ack);
    logic v;
    b = 8'h00; p = 1'b0; s = 1'b0;
    repeat (H) @(posedge clk_sys);
    st = dat_line;
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(posedge clk_sys);
      v = dat_line;
      dev_clk = 1'b1;
      if (i < 8) b[i] = v;
      else if (i == 8) p = v;
      else s = v;
      repeat (H) @(posedge clk_sys);
    end
    if (ack) dev_dat = 1'b0;
    dev_clk = 1'b0;
    repeat (H) @(posedge clk_sys);
    dev_clk = 1'b1;
    repeat (H) @(posedge clk_sys);
    dev_dat = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b_rxv, b_rxe, b_txd, b_txe, lc;
    logic [7:0] rb;
    logic rp, rs, rst_bit;

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_clk_out", ps2_clk_out, 1);
    chk("rst_dat_out", ps2_dat_out, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_pulses", {rx_valid, rx_err, tx_done, tx_err}, 4'b0000);
    rst_n = 1'b1;
    repeat (4) @(posedge clk_sys);

    // Inhibit while idle pulls the clock low, release lets it go.
    rx_inhibit = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("inhibit_low", ps2_clk_out, 0);
    rx_inhibit = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("inhibit_rel", ps2_clk_out, 1);

    // 0x1C has three ones: parity 0.
    b_rxv = n_rxv; b_rxe = n_rxe;
    dev_frame({1'b1, 1'b0, 8'h1C, 1'b0}, 11);
    chk("rx1c_valid", n_rxv - b_rxv, 1);
    chk("rx1c_err", n_rxe - b_rxe, 0);
    chk("rx1c_data", rx_data, 8'h1C);

    // Wrong parity: error, data retained.
    b_rxv = n_rxv; b_rxe = n_rxe;
    dev_frame({1'b1, 1'b1, 8'h1C, 1'b0}, 11);
    chk("badpar_valid", n_rxv - b_rxv, 0);
    chk("badpar_err", n_rxe - b_rxe, 1);
    chk("badpar_data", rx_data, 8'h1C);

    // 0x00 needs parity 1.
    b_rxv = n_rxv;
    dev_frame({1'b1, 1'b1, 8'h00, 1'b0}, 11);
    chk("rx00_valid", n_rxv - b_rxv, 1);
    chk("rx00_data", rx_data, 8'h00);

    // Stop bit 0 with correct parity (0x55, four ones -> parity 1).
    b_rxv = n_rxv; b_rxe = n_rxe;
    dev_frame({1'b0, 1'b1, 8'h55, 1'b0}, 11);
    chk("badstop_err", n_rxe - b_rxe, 1);
    chk("badstop_valid", n_rxv - b_rxv, 0);
    chk("badstop_data", rx_data, 8'h00);

    // Transmit 0xFF, with a second tx_start during inhibit that must be ignored.
    b_txd = n_txd; b_txe = n_txe;
    tx_go(8'hFF);
    fork
      dev_wait_release(lc);
      begin
        repeat (10) @(negedge clk_sys);
        tx_data = 8'h00; tx_start = 1'b1;
        @(negedge clk_sys);
        tx_start = 1'b0; tx_data = 8'hFF;
      end
    join
    chk("txff_inhibit_len", lc, 3000);
    dev_host_rx(rb, rp, rs, rst_bit, 1'b1);
    chk("txff_start", rst_bit, 0);
    chk("txff_byte", rb, 8'hFF);
    chk("txff_par", rp, 1);
    chk("txff_stop", rs, 1);
    chk("txff_done", n_txd - b_txd, 1);
    chk("txff_err", n_txe - b_txe, 0);
    chk("txff_busy", tx_busy, 0);

    // Receive of 0xAA aborted after its 4th data bit by a 0xF4 command.
    b_rxv = n_rxv; b_rxe = n_rxe; b_txd = n_txd;
    dev_frame({1'b1, 1'b1, 8'hAA, 1'b0}, 5);
    tx_go(8'hF4);
    dev_wait_release(lc);
    chk("abort_inhibit_len", lc, 3000);
    dev_host_rx(rb, rp, rs, rst_bit, 1'b1);
    chk("abort_byte", rb, 8'hF4);
    chk("abort_par", rp, 0);
    chk("abort_stop", rs, 1);
    chk("abort_done", n_txd - b_txd, 1);
    chk("abort_rx_pulses", (n_rxv - b_rxv) + (n_rxe - b_rxe), 0);
    chk("abort_rx_data", rx_data, 8'h00);

`ifdef PS2_HOST_TIMEOUT_EN
    // Silent device: tx_err 100 cycles after RTS.
    begin
      int n;
      b_txe = n_txe;
      tx_go(8'hED);
      dev_wait_release(lc);
      n = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk_sys);
        if (tx_err) break;
        n++;
      end
      chk("to_cycles", n, 99);
      chk("to_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);
      chk("to_busy", tx_busy, 0);
      @(negedge clk_sys);
      chk("to_err_count", n_txe - b_txe, 1);
    end
`endif

    // Reset during TX_DATA (host driving bit 2 of 0x5A, which is 0).
    tx_go(8'h5A);
    dev_wait_release(lc);
    repeat (H) @(posedge clk_sys);
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(posedge clk_sys);
      if (i < 2) begin
        dev_clk = 1'b1;
        repeat (H) @(posedge clk_sys);
      end
    end
    @(negedge clk_sys);
    chk("pre_rst_dat", ps2_dat_out, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);
    chk("midrst_busy", tx_busy, 0);
    dev_clk = 1'b1;
    repeat (5) @(posedge clk_sys);
    rst_n = 1'b1;
    repeat (5) @(posedge clk_sys);

    b_rxv = n_rxv;
    dev_frame({1'b1, 1'b0, 8'h1C, 1'b0}, 11);
    chk("postrst_valid", n_rxv - b_rxv, 1);
    chk("postrst_data", rx_data, 8'h1C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
